// File: rtl/execute_memory_stage_buffer_if.sv
// ---------------------------------------------------------------------------
// execute_memory_stage_buffer_if
//
// Bundles every signal that crosses the EX->MEM boundary: the execute-side
// valid/ready handshake with its payload, and the memory-side valid/ready
// handshake with the head-entry payload, plus the occupancy count.
//
// Modports:
//   slave  - the stage buffer itself (takes execute payload, drives memory
//            payload, valid_memory, ready_execute and occupancy)
//   master - the surrounding pipeline (execute drives its payload and
//            valid_execute, memory drives ready_memory)
// ---------------------------------------------------------------------------
interface execute_memory_stage_buffer_if #(
    parameter int SCALAR_W   = 16,
    parameter int VECTOR_W   = 128,
    parameter int REG_ADDR_W = 5,
    parameter int WB_SEL_W   = 2
);

    // Execute side
    logic                  valid_execute;
    logic                  ready_execute;
    logic                  wre_execute;
    logic                  vector_wre_execute;
    logic                  write_memory_enable_a_execute;
    logic                  write_memory_enable_b_execute;
    logic [WB_SEL_W-1:0]   select_writeback_data_mux_execute;
    logic [WB_SEL_W-1:0]   select_writeback_vector_data_mux_execute;
    logic [SCALAR_W-1:0]   ALUresult_in;
    logic [SCALAR_W-1:0]   srcA_execute;
    logic [SCALAR_W-1:0]   srcB_execute;
    logic [VECTOR_W-1:0]   ALUvectorResult_in;
    logic [VECTOR_W-1:0]   vector_srcB_execute;
    logic [REG_ADDR_W-1:0] rs1_execute;
    logic [REG_ADDR_W-1:0] rs2_execute;
    logic [REG_ADDR_W-1:0] rd_execute;

    // Memory side
    logic                  valid_memory;
    logic                  ready_memory;
    logic                  wre_memory;
    logic                  vector_wre_memory;
    logic                  write_memory_enable_a_memory;
    logic                  write_memory_enable_b_memory;
    logic [WB_SEL_W-1:0]   select_writeback_data_mux_memory;
    logic [WB_SEL_W-1:0]   select_writeback_vector_data_mux_memory;
    logic [SCALAR_W-1:0]   ALUresult_out;
    logic [SCALAR_W-1:0]   srcA_memory;
    logic [SCALAR_W-1:0]   srcB_memory;
    logic [VECTOR_W-1:0]   ALUvectorResult_out;
    logic [VECTOR_W-1:0]   vector_srcB_memory;
    logic [REG_ADDR_W-1:0] rs1_memory;
    logic [REG_ADDR_W-1:0] rs2_memory;
    logic [REG_ADDR_W-1:0] rd_memory;

    logic [1:0]            occupancy;

    modport slave (
        input  valid_execute,
        output ready_execute,
        input  wre_execute,
        input  vector_wre_execute,
        input  write_memory_enable_a_execute,
        input  write_memory_enable_b_execute,
        input  select_writeback_data_mux_execute,
        input  select_writeback_vector_data_mux_execute,
        input  ALUresult_in,
        input  srcA_execute,
        input  srcB_execute,
        input  ALUvectorResult_in,
        input  vector_srcB_execute,
        input  rs1_execute,
        input  rs2_execute,
        input  rd_execute,
        output valid_memory,
        input  ready_memory,
        output wre_memory,
        output vector_wre_memory,
        output write_memory_enable_a_memory,
        output write_memory_enable_b_memory,
        output select_writeback_data_mux_memory,
        output select_writeback_vector_data_mux_memory,
        output ALUresult_out,
        output srcA_memory,
        output srcB_memory,
        output ALUvectorResult_out,
        output vector_srcB_memory,
        output rs1_memory,
        output rs2_memory,
        output rd_memory,
        output occupancy
    );

    modport master (
        output valid_execute,
        input  ready_execute,
        output wre_execute,
        output vector_wre_execute,
        output write_memory_enable_a_execute,
        output write_memory_enable_b_execute,
        output select_writeback_data_mux_execute,
        output select_writeback_vector_data_mux_execute,
        output ALUresult_in,
        output srcA_execute,
        output srcB_execute,
        output ALUvectorResult_in,
        output vector_srcB_execute,
        output rs1_execute,
        output rs2_execute,
        output rd_execute,
        input  valid_memory,
        output ready_memory,
        input  wre_memory,
        input  vector_wre_memory,
        input  write_memory_enable_a_memory,
        input  write_memory_enable_b_memory,
        input  select_writeback_data_mux_memory,
        input  select_writeback_vector_data_mux_memory,
        input  ALUresult_out,
        input  srcA_memory,
        input  srcB_memory,
        input  ALUvectorResult_out,
        input  vector_srcB_memory,
        input  rs1_memory,
        input  rs2_memory,
        input  rd_memory,
        input  occupancy
    );

endinterface

// File: rtl/execute_memory_stage_buffer.sv
// ---------------------------------------------------------------------------
// execute_memory_stage_buffer
//
// Two-entry elastic buffer sitting between the execute and memory stages.
// A head slot feeds the memory stage; a skid slot catches one extra entry
// when memory stalls, so ready_execute depends only on registered state and
// execute never has to recompute a result.
//
// Ports:
//   clk    - rising-edge clock for all state
//   reset  - synchronous, active-high; empties the buffer and zeroes both slots
//   flush  - synchronous kill of all buffered entries and the incoming entry
//   bus    - execute_memory_stage_buffer_if.slave: execute payload with
//            valid_execute/ready_execute, memory payload with
//            valid_memory/ready_memory, and the 2-bit occupancy count
// ---------------------------------------------------------------------------
module execute_memory_stage_buffer #(
    parameter int SCALAR_W   = 16,
    parameter int VECTOR_W   = 128,
    parameter int REG_ADDR_W = 5,
    parameter int WB_SEL_W   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    execute_memory_stage_buffer_if.slave  bus
);

    // Encodings double as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  wre;
        logic                  vector_wre;
        logic                  mem_en_a;
        logic                  mem_en_b;
        logic [WB_SEL_W-1:0]   sel_wb;
        logic [WB_SEL_W-1:0]   sel_vector_wb;
        logic [SCALAR_W-1:0]   alu_result;
        logic [SCALAR_W-1:0]   src_a;
        logic [SCALAR_W-1:0]   src_b;
        logic [VECTOR_W-1:0]   alu_vector_result;
        logic [VECTOR_W-1:0]   vector_src_b;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t incoming;

    logic accept;
    logic pop;
    logic valid_head;
    logic ready_in;

    // Gather the execute-side payload into one entry.
    always_comb begin
        incoming.wre               = bus.wre_execute;
        incoming.vector_wre        = bus.vector_wre_execute;
        incoming.mem_en_a          = bus.write_memory_enable_a_execute;
        incoming.mem_en_b          = bus.write_memory_enable_b_execute;
        incoming.sel_wb            = bus.select_writeback_data_mux_execute;
        incoming.sel_vector_wb     = bus.select_writeback_vector_data_mux_execute;
        incoming.alu_result        = bus.ALUresult_in;
        incoming.src_a             = bus.srcA_execute;
        incoming.src_b             = bus.srcB_execute;
        incoming.alu_vector_result = bus.ALUvectorResult_in;
        incoming.vector_src_b      = bus.vector_srcB_execute;
        incoming.rs1               = bus.rs1_execute;
        incoming.rs2               = bus.rs2_execute;
        incoming.rd                = bus.rd_execute;
    end

    // Handshake terms; ready_in uses registered state only, which keeps
    // ready_memory out of the execute-side ready path.
    assign valid_head = (state_q != EMPTY);
    assign ready_in   = (state_q != TWO);
    assign accept     = bus.valid_execute & ready_in & ~flush;
    assign pop        = valid_head & bus.ready_memory;

    // Next-state and slot-update logic. Flush overrides everything; slot
    // contents are left alone because an empty buffer never shows them.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        head_d  = incoming;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = incoming;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = incoming;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and slot registers; reset wins over flush and clears both slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // Side-effecting controls are masked during a bubble so a stale head
    // entry can never write; data fields simply show the last head contents.
    assign bus.ready_execute                = ready_in;
    assign bus.valid_memory                 = valid_head;
    assign bus.occupancy                    = state_q;
    assign bus.wre_memory                   = head_q.wre        & valid_head;
    assign bus.vector_wre_memory            = head_q.vector_wre & valid_head;
    assign bus.write_memory_enable_a_memory = head_q.mem_en_a   & valid_head;
    assign bus.write_memory_enable_b_memory = head_q.mem_en_b   & valid_head;

    assign bus.select_writeback_data_mux_memory        = head_q.sel_wb;
    assign bus.select_writeback_vector_data_mux_memory = head_q.sel_vector_wb;
    assign bus.ALUresult_out                           = head_q.alu_result;
    assign bus.srcA_memory                             = head_q.src_a;
    assign bus.srcB_memory                             = head_q.src_b;
    assign bus.ALUvectorResult_out                     = head_q.alu_vector_result;
    assign bus.vector_srcB_memory                      = head_q.vector_src_b;
    assign bus.rs1_memory                              = head_q.rs1;
    assign bus.rs2_memory                              = head_q.rs2;
    assign bus.rd_memory                               = head_q.rd;

endmodule

// File: doc/execute_memory_stage_buffer.md
Name: execute_memory_stage_buffer

Overview:
- Parametrised EX→MEM pipeline boundary. Replaces the plain always-load stage register with a 2-entry elastic buffer.
- Carries scalar and vector results, operand copies, register addresses and memory/writeback controls from execute to memory.
- Adds a valid/ready handshake, back-pressure from memory (e.g. multi-cycle vector stores), flush, and bubble insertion, so the pipeline can stall without recomputing execute.

Parameters:
- SCALAR_W, 16, width of ALU scalar result and srcA/srcB
- VECTOR_W, 128, width of vector ALU result and vector_srcB
- REG_ADDR_W, 5, width of rs1/rs2/rd
- WB_SEL_W, 2, width of both writeback mux selects

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  kill all buffered entries and the incoming entry
- valid_execute  in  1  execute presents a valid entry
- ready_execute  out  1  buffer can accept an entry this cycle
- wre_execute, vector_wre_execute, write_memory_enable_a_execute, write_memory_enable_b_execute  in  1 each  control enables
- select_writeback_data_mux_execute, select_writeback_vector_data_mux_execute  in  WB_SEL_W each
- ALUresult_in, srcA_execute, srcB_execute  in  SCALAR_W each
- ALUvectorResult_in, vector_srcB_execute  in  VECTOR_W each
- rs1_execute, rs2_execute, rd_execute  in  REG_ADDR_W each
- valid_memory  out  1  head entry valid
- ready_memory  in  1  memory stage consumes head entry
- *_memory / *_out  out  same widths as the matching input  head-entry fields (wre_memory, vector_wre_memory, write_memory_enable_a/b_memory, select_*_memory, ALUresult_out, ALUvectorResult_out, srcA/srcB_memory, vector_srcB_memory, rs1/rs2/rd_memory)
- occupancy  out  2  entries held (0..2)

Behaviour:
- Storage: head slot H and skid slot S. State EMPTY (0), ONE (H valid), TWO (H and S valid). occupancy encodes the state.
- Acceptance and consumption:
  - accept = valid_execute & ready_execute & ~flush
  - pop = valid_memory & ready_memory
- ready_execute = (state != TWO). It is a function of registered state only, with no combinational path from ready_memory.
- Transitions, evaluated at the clock edge:
  - EMPTY: accept → ONE, load H. Else stay.
  - ONE: accept & pop → ONE, H←input. accept & ~pop → TWO, S←input. ~accept & pop → EMPTY. Else hold.
  - TWO: pop → ONE, H←S. No accept is possible in TWO. Else hold.
- Ordering is strict FIFO. Latency EMPTY→valid_memory is 1 cycle. Throughput is 1 entry/cycle when ready_memory is held high.
- valid_memory = (state != EMPTY).
- Bubble rule: when valid_memory=0, wre_memory, vector_wre_memory, write_memory_enable_a_memory and write_memory_enable_b_memory are forced 0. Data/address/select outputs keep the last H contents (don't-care).
- Entries with valid_execute=0 are never stored, so controls of a non-valid input have no effect.
- flush (synchronous, priority over accept/pop): next state EMPTY, and any input offered that cycle is dropped. Outputs the same cycle are unaffected; they show bubble from the next cycle. ready_execute is 1 the cycle after flush.
- reset has priority over flush. Next cycle: state EMPTY, H/S cleared to all-zero, all outputs 0 except ready_execute=1. Reset mid-operation discards up to 2 entries with no partial writeback.
- Width rules:
  - All fields are stored unmodified at parameter width, with no truncation or extension.
  - Reset clear values are sized to each field's parameter width (ALUresult is SCALAR_W zeros).
- Simultaneous events:
  - accept+pop in ONE keeps occupancy 1 with no bubble.
  - pop in TWO with valid_execute=1 leaves the input un-accepted; execute must hold it until ready_execute.
- Protocol requirement on execute: once valid_execute is high with ready_execute low, inputs stay stable until accepted or flushed.

Test Plan:
- Reset then stream: valid_execute=1 and ready_memory=1 for 4 cycles with ALUresult_in=0x0001..0x0004, rd=1..4 → valid_memory from cycle 1, ALUresult_out 0x0001..0x0004 on consecutive cycles, occupancy stays 1.
- Back-pressure: ready_memory=0 while 3 entries (A=0x00AA, B=0x00BB, C=0x00CC) are offered.
  - Required: occupancy 1 then 2, ready_execute=0 after B, C held.
  - Then ready_memory=1: outputs A, B, C in order, one cycle apart, with no duplicate or loss.
- Vector path: ALUvectorResult_in=128'h0123…CDEF, vector_wre_execute=1 with a 1-cycle memory stall → ALUvectorResult_out holds the value for 2 cycles, vector_wre_memory=1 both cycles, then 0 on the bubble.
- Flush in TWO while valid_execute=1 and wre_execute=1 → next cycle valid_memory=0, wre_memory=0, write_memory_enable_a/b_memory=0, occupancy=0, ready_execute=1. The flushed input never appears.
- Reset mid-stall: occupancy=2, assert reset for 1 cycle → all outputs 0, ready_execute=1. The next accepted entry (ALUresult_in=0x1234) appears alone, one cycle later.
- Parameter sweep: SCALAR_W=32, VECTOR_W=256, REG_ADDR_W=6 → run the stream and back-pressure tests. Full-width patterns (all-ones, 0x5…A alternating) pass unmodified, and the reset value is all-zero across the full width.
